// File: rtl/keypad_debounce_if.sv
// Keypad debouncer bus: raw key lines and config in, debounced pattern and events out.
interface keypad_debounce_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 32
);
  logic             en;
  logic [WIDTH-1:0] key_in;
  logic [CNT_W-1:0] debounce_period;
  logic [WIDTH-1:0] pattern;
  logic             press_pulse;
  logic             release_pulse;
  logic             held;
  logic             error;

  modport master (
    output en, key_in, debounce_period,
    input  pattern, press_pulse, release_pulse, held, error
  );

  modport slave (
    input  en, key_in, debounce_period,
    output pattern, press_pulse, release_pulse, held, error
  );
endinterface

// File: rtl/keypad_debounce_fsm.sv
// Keypad line debouncer: 2-flop synchroniser followed by a press/release FSM that debounces
// the whole WIDTH-bit pattern and flags illegal multi-key patterns.
module keypad_debounce_fsm #(
  parameter int unsigned WIDTH        = 4,
  parameter int unsigned CNT_W        = 32,
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter bit          ONEHOT_CHECK = 1'b1
) (
  input logic                clk_i,
  input logic                rst_i,
  keypad_debounce_if.slave   bus_io
);

  localparam logic [WIDTH-1:0] Inactive = ACTIVE_LOW ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic [1:0] {StIdle, StPressWait, StHeld, StRelWait} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] act;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             reached;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             held;

  function automatic logic is_legal(input logic [WIDTH-1:0] p);
    return !ONEHOT_CHECK || ($countones(p) == 1);
  endfunction

  assign act        = ACTIVE_LOW ? ~sync2_q : sync2_q;
  assign period_eff = (bus_io.debounce_period == '0) ? CNT_W'(1) : bus_io.debounce_period;
  assign cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  // Compared live so a period change mid-count applies on the very next cycle.
  assign reached    = (cnt_q >= period_eff);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= Inactive;
      sync2_q <= Inactive;
    end else begin
      sync1_q <= bus_io.key_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cand_q    <= '0;
      pattern_q <= '0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      pattern_q <= pattern_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    pattern_d = pattern_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (bus_io.en) begin
      case (state_q)
        StIdle: begin
          if (act != '0) begin
            state_d = StPressWait;
            cand_d  = act;
            cnt_d   = CNT_W'(1);
          end
        end
        StPressWait: begin
          if (act == '0) begin
            state_d = StIdle;
          end else if (act != cand_q) begin
            cand_d = act;
            cnt_d  = CNT_W'(1);
          end else if (reached) begin
            state_d   = StHeld;
            pattern_d = cand_q;
            press_d   = is_legal(cand_q);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StHeld: begin
          if (act != pattern_q) begin
            state_d = StRelWait;
            cnt_d   = CNT_W'(1);
          end
        end
        StRelWait: begin
          // Any pattern other than the held one, including a new key, counts as release.
          if (act == pattern_q) begin
            state_d = StHeld;
          end else if (reached) begin
            state_d   = StIdle;
            pattern_d = '0;
            release_d = is_legal(pattern_q);
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign held                 = (state_q == StHeld) || (state_q == StRelWait);
  assign bus_io.pattern       = pattern_q;
  assign bus_io.press_pulse   = press_q;
  assign bus_io.release_pulse = release_q;
  assign bus_io.held          = held;
  assign bus_io.error         = held & ~is_legal(pattern_q);

endmodule

// File: tb/tb_keypad_debounce_fsm.sv
// Directed bench for keypad_debounce_fsm: one-hot-checking and permissive instances share stimulus.
module tb_keypad_debounce_fsm;

  localparam int unsigned W = 4;
  localparam int unsigned C = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] key_in;
  logic [C-1:0] period;

  int n_checks = 0;
  int n_pass   = 0;
  int press_a = 0, release_a = 0, press_b = 0, release_b = 0;

  keypad_debounce_if #(.WIDTH(W), .CNT_W(C)) bus_a ();
  keypad_debounce_if #(.WIDTH(W), .CNT_W(C)) bus_b ();

  assign bus_a.en              = en;
  assign bus_a.key_in          = key_in;
  assign bus_a.debounce_period = period;
  assign bus_b.en              = en;
  assign bus_b.key_in          = key_in;
  assign bus_b.debounce_period = period;

  keypad_debounce_fsm #(
    .WIDTH(W), .CNT_W(C), .ACTIVE_LOW(1'b1), .ONEHOT_CHECK(1'b1)
  ) u_dut_a (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus_a)
  );

  keypad_debounce_fsm #(
    .WIDTH(W), .CNT_W(C), .ACTIVE_LOW(1'b1), .ONEHOT_CHECK(1'b0)
  ) u_dut_b (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_io (bus_b)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus_a.press_pulse)   press_a++;
    if (bus_a.release_pulse) release_a++;
    if (bus_b.press_pulse)   press_b++;
    if (bus_b.release_pulse) release_b++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles from now until the chosen pulse of instance A is seen; -1 if the budget expires.
  task automatic wait_pulse(input bit rel, input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if ((rel ? bus_a.release_pulse : bus_a.press_pulse) == 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  int lat_p5, lat_rel5, lat_p1, lat_p0, lat, base_p, base_r, base_pb, base_rb;

  initial begin
    rst    = 1'b1;
    en     = 1'b1;
    key_in = 4'b1111;
    period = 32'd5;
    tick(3);
    check_val("rst_pattern", {28'd0, bus_a.pattern}, 32'd0);
    check_val("rst_held",    {31'd0, bus_a.held}, 32'd0);
    check_val("rst_press",   {31'd0, bus_a.press_pulse}, 32'd0);
    check_val("rst_release", {31'd0, bus_a.release_pulse}, 32'd0);
    check_val("rst_error",   {31'd0, bus_a.error}, 32'd0);
    rst = 1'b0;
    tick(3);

    // Clean press and release with period 5.
    base_p = press_a; base_r = release_a;
    key_in = 4'b1101;
    wait_pulse(1'b0, 40, lat_p5);
    check_val("clean_pattern", {28'd0, bus_a.pattern}, 32'd2);
    check_val("clean_held",    {31'd0, bus_a.held}, 32'd1);
    tick(20);
    check_val("clean_one_press", press_a - base_p, 32'd1);
    key_in = 4'b1111;
    wait_pulse(1'b1, 40, lat_rel5);
    check_val("clean_rel_spacing", lat_rel5, lat_p5);
    tick(1);
    check_val("clean_rel_pattern", {28'd0, bus_a.pattern}, 32'd0);
    check_val("clean_rel_held",    {31'd0, bus_a.held}, 32'd0);
    check_val("clean_one_release", release_a - base_r, 32'd1);
    tick(5);

    // Period 1 and period 0 accept identically; period 5 adds four more stable cycles.
    period = 32'd1;
    key_in = 4'b1101;
    wait_pulse(1'b0, 40, lat_p1);
    key_in = 4'b1111;
    tick(12);
    period = 32'd0;
    key_in = 4'b1101;
    wait_pulse(1'b0, 40, lat_p0);
    key_in = 4'b1111;
    tick(12);
    check_val("p0_eq_p1", lat_p0, lat_p1);
    check_val("p5_minus_p1", lat_p5 - lat_p1, 32'd4);
    period = 32'd5;

    // Press bounce: toggles every 2 cycles never reach 5 stable cycles.
    base_p = press_a;
    for (int i = 0; i < 4; i++) begin
      key_in = (i % 2 == 0) ? 4'b1101 : 4'b1111;
      tick(2);
    end
    check_val("bounce_no_press", press_a - base_p, 32'd0);
    key_in = 4'b1101;
    wait_pulse(1'b0, 40, lat);
    check_val("bounce_press_lat", lat, lat_p5);
    tick(10);
    check_val("bounce_one_press", press_a - base_p, 32'd1);

    // Release bounce: 3 inactive cycles fall short of 5, so the key stays held.
    base_r = release_a;
    key_in = 4'b1111;
    tick(3);
    key_in = 4'b1101;
    tick(12);
    check_val("relbounce_none", release_a - base_r, 32'd0);
    check_val("relbounce_held", {31'd0, bus_a.held}, 32'd1);
    key_in = 4'b1111;
    tick(12);
    check_val("relbounce_one", release_a - base_r, 32'd1);

    // Two keys at once: illegal for A, legal for B.
    base_p = press_a; base_r = release_a; base_pb = press_b; base_rb = release_b;
    key_in = 4'b1001;
    tick(12);
    check_val("multi_held",    {31'd0, bus_a.held}, 32'd1);
    check_val("multi_error",   {31'd0, bus_a.error}, 32'd1);
    check_val("multi_pattern", {28'd0, bus_a.pattern}, 32'd6);
    check_val("multi_no_press", press_a - base_p, 32'd0);
    check_val("multi_b_press",  press_b - base_pb, 32'd1);
    check_val("multi_b_error",  {31'd0, bus_b.error}, 32'd0);
    key_in = 4'b1111;
    tick(12);
    check_val("multi_no_release", release_a - base_r, 32'd0);
    check_val("multi_error_clr",  {31'd0, bus_a.error}, 32'd0);
    check_val("multi_b_release",  release_b - base_rb, 32'd1);

    // Lower the period from 100 to 3 once the counter has reached 10.
    base_p = press_a;
    period = 32'd100;
    key_in = 4'b1101;
    tick(12);
    check_val("midcnt_none", press_a - base_p, 32'd0);
    period = 32'd3;
    tick(1);
    check_val("midcnt_press", {31'd0, bus_a.press_pulse}, 32'd1);
    key_in = 4'b1111;
    tick(12);
    period = 32'd5;

    // Enable low for 7 cycles mid press-wait delays press by exactly 7 cycles.
    base_p = press_a;
    key_in = 4'b1101;
    tick(4);
    en = 1'b0;
    tick(7);
    check_val("en_frozen", press_a - base_p, 32'd0);
    en = 1'b1;
    wait_pulse(1'b0, 40, lat);
    check_val("en_delay", lat + 11, lat_p5 + 7);

    // Reset while held clears outputs at once and gives no release.
    tick(3);
    check_val("rsthold_held", {31'd0, bus_a.held}, 32'd1);
    base_r = release_a;
    rst = 1'b1;
    #1;
    check_val("rsthold_outs",
              {26'd0, bus_a.pattern, bus_a.held, bus_a.error},
              32'd0);
    key_in = 4'b1111;
    tick(3);
    rst = 1'b0;
    tick(12);
    check_val("rsthold_no_rel", release_a - base_r, 32'd0);
    check_val("rsthold_idle",   {31'd0, bus_a.held}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
